secuencia_lectura: RTL and testbench

Read-cycle sequencer for the multiplexed 8-bit address/data bus of the external RTC chip. It is the read-side companion of the write-cycle timing counter. On a start pulse it drives one full bus read: address phase, bus turnaround, data phase with sampling, then hold. It returns the captured byte with a one-cycle done pulse. It sits between the control FSM (which issues start/addr) and the bidirectional bus pad logic.

---
 rtl/secuencia_lectura.sv | 132 +++++++++++++
 tb/tb_secuencia_lectura.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/secuencia_lectura.sv
// Read-cycle sequencer for the multiplexed address/data bus of the external RTC.
// Runs one bus read per accepted start: address, turnaround, data, and hold
// phases. It then returns the captured byte together with a one-cycle done pulse.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | strobes inactive, bus released, waiting for start
// S_ADDR | cs_n/wr_n/ad_n low, latched address driven onto the bus
// S_GAP  | all strobes high, bus released for turnaround
// S_READ | cs_n/rd_n low, chip drives data; sampled on the last cycle
// S_HOLD | all strobes high, recovery before reporting completion
module secuencia_lectura #(
   parameter int T_ADDR = 20,
   parameter int T_GAP  = 10,
   parameter int T_RD   = 20,
   parameter int T_HOLD = 10,
   parameter int CW     = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] addr,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic       ad_n,
   output logic [7:0] dato,
   output logic       busy,
   output logic       fin_rd
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_GAP,
      S_READ,
      S_HOLD
   } state_t;

   // Terminal counts: a phase ends on the edge where the counter reaches T-1.
   localparam logic [CW-1:0] LAST_ADDR = CW'(T_ADDR - 1);
   localparam logic [CW-1:0] LAST_GAP  = CW'(T_GAP - 1);
   localparam logic [CW-1:0] LAST_RD   = CW'(T_RD - 1);
   localparam logic [CW-1:0] LAST_HOLD = CW'(T_HOLD - 1);

   state_t        state;
   logic [CW-1:0] cnt;

   // Sequencer FSM. Each output is loaded with the value for the state being
   // entered, so the pins change on the same edge as the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         cs_n   <= 1'b1;
         rd_n   <= 1'b1;
         wr_n   <= 1'b1;
         ad_n   <= 1'b1;
         ad_oe  <= 1'b0;
         ad_out <= 8'h00;
         dato   <= 8'h00;
         busy   <= 1'b0;
         fin_rd <= 1'b0;
      end else begin
         fin_rd <= 1'b0;
         cnt    <= cnt + 1'b1;
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (start) begin
                  state  <= S_ADDR;
                  ad_out <= addr;
                  cs_n   <= 1'b0;
                  wr_n   <= 1'b0;
                  ad_n   <= 1'b0;
                  ad_oe  <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            S_ADDR: begin
               if (cnt == LAST_ADDR) begin
                  state <= S_GAP;
                  cnt   <= '0;
                  cs_n  <= 1'b1;
                  wr_n  <= 1'b1;
                  ad_n  <= 1'b1;
                  ad_oe <= 1'b0;
               end
            end
            S_GAP: begin
               if (cnt == LAST_GAP) begin
                  state <= S_READ;
                  cnt   <= '0;
                  cs_n  <= 1'b0;
                  rd_n  <= 1'b0;
               end
            end
            S_READ: begin
               if (cnt == LAST_RD) begin
                  state <= S_HOLD;
                  cnt   <= '0;
                  cs_n  <= 1'b1;
                  rd_n  <= 1'b1;
                  dato  <= ad_in;
               end
            end
            S_HOLD: begin
               if (cnt == LAST_HOLD) begin
                  state  <= S_IDLE;
                  cnt    <= '0;
                  busy   <= 1'b0;
                  fin_rd <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
               cs_n  <= 1'b1;
               rd_n  <= 1'b1;
               wr_n  <= 1'b1;
               ad_n  <= 1'b1;
               ad_oe <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_secuencia_lectura.sv
// Bench for secuencia_lectura: a default-timing instance with a scoreboard of
// expected read bytes, plus a minimum-timing instance (all phases one cycle).
module tb_secuencia_lectura;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, start1;
   logic [7:0] addr, addr1;
   logic [7:0] bus_val, bus_val1;
   logic [7:0] ad_in, ad_in1;
   logic [7:0] ad_out, ad_out1, dato, dato1;
   logic       ad_oe, cs_n, rd_n, wr_n, ad_n, busy, fin_rd;
   logic       ad_oe1, cs_n1, rd_n1, wr_n1, ad_n1, busy1, fin_rd1;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   // The RTC drives the bus only while the read strobe is low.
   assign ad_in  = rd_n  ? 8'h00 : bus_val;
   assign ad_in1 = rd_n1 ? 8'h00 : bus_val1;

   secuencia_lectura dut (
      .clk(clk), .reset(reset), .start(start), .addr(addr), .ad_in(ad_in),
      .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
      .ad_n(ad_n), .dato(dato), .busy(busy), .fin_rd(fin_rd)
   );

   secuencia_lectura #(.T_ADDR(1), .T_GAP(1), .T_RD(1), .T_HOLD(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .addr(addr1), .ad_in(ad_in1),
      .ad_out(ad_out1), .ad_oe(ad_oe1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1),
      .ad_n(ad_n1), .dato(dato1), .busy(busy1), .fin_rd(fin_rd1)
   );

   // Expected {cs_n,rd_n,wr_n,ad_n,ad_oe,busy,fin_rd} for cycle i after acceptance.
   function automatic logic [6:0] exp_vec(int i, int ta, int tg, int tr, int th);
      int total;
      total = ta + tg + tr + th;
      if (i < ta)                return 7'b0100110;
      else if (i < ta + tg)      return 7'b1111010;
      else if (i < ta + tg + tr) return 7'b0011010;
      else if (i < total)        return 7'b1111010;
      else if (i == total)       return 7'b1111001;
      else                       return 7'b1111000;
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding read.
   always @(negedge clk) begin
      if (!reset && fin_rd) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_fin: fin_rd=1 with no read outstanding, dato=%h", dato);
         end else begin
            logic [7:0] e;
            e = sb.pop_front();
            if (dato !== e) begin
               n_fail++;
               $display("FAIL sb_dato: got %h expected %h", dato, e);
            end
         end
      end
   end

   // Bus safety: never both strobes low, never driving while the chip drives.
   always @(negedge clk) begin
      if (!reset) begin
         n_checks++;
         if (!rd_n && (!wr_n || ad_oe)) begin
            n_fail++;
            $display("FAIL bus_conflict: rd_n=%b wr_n=%b ad_oe=%b required no overlap", rd_n, wr_n, ad_oe);
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1; start = 0; start1 = 0; addr = 0; addr1 = 0; bus_val = 0; bus_val1 = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++;
         if ({cs_n, rd_n, wr_n, ad_n, ad_oe, busy, fin_rd} !== 7'b1111000 || dato !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_idle: cyc %0d pins=%b dato=%h required 1111000 / 00", i,
                     {cs_n, rd_n, wr_n, ad_n, ad_oe, busy, fin_rd}, dato);
         end
      end
   endtask

   // Pulse start for one cycle; returns at the negedge of cycle 0 of the read.
   task automatic pulse_start(input logic [7:0] a, input logic [7:0] d);
      addr = a; bus_val = d; start = 1'b1;
      sb.push_back(d);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_single_read();
      pulse_start(8'h23, 8'h47);
      for (int i = 0; i <= 62; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 1) addr = 8'h55;
         n_checks++;
         if ({cs_n, rd_n, wr_n, ad_n, ad_oe, busy, fin_rd} !== exp_vec(i, 20, 10, 20, 10)) begin
            n_fail++;
            $display("FAIL single_pins: cyc %0d got %b required %b", i,
                     {cs_n, rd_n, wr_n, ad_n, ad_oe, busy, fin_rd}, exp_vec(i, 20, 10, 20, 10));
         end
         if (i < 20) begin
            n_checks++;
            if (ad_out !== 8'h23) begin
               n_fail++;
               $display("FAIL single_ad_out: cyc %0d got %h required 23", i, ad_out);
            end
         end
         if (i == 60) begin
            n_checks++;
            if (dato !== 8'h47) begin
               n_fail++;
               $display("FAIL single_dato: got %h required 47", dato);
            end
         end
      end
   endtask

   task automatic test_ignore_start();
      int fins;
      fins = 0;
      pulse_start(8'h23, 8'h47);
      for (int i = 0; i <= 70; i++) begin
         if (i > 0) @(negedge clk);
         n_checks++;
         if ({cs_n, rd_n, wr_n, ad_n, ad_oe, busy, fin_rd} !== exp_vec(i, 20, 10, 20, 10)) begin
            n_fail++;
            $display("FAIL ignore_pins: cyc %0d got %b required %b", i,
                     {cs_n, rd_n, wr_n, ad_n, ad_oe, busy, fin_rd}, exp_vec(i, 20, 10, 20, 10));
         end
         if (fin_rd) fins++;
         if (i == 40) begin start = 1'b1; addr = 8'h99; end
         if (i == 41) start = 1'b0;
      end
      n_checks++;
      if (fins != 1 || ad_out !== 8'h23) begin
         n_fail++;
         $display("FAIL ignore_count: fin pulses %0d ad_out %h required 1 / 23", fins, ad_out);
      end
   endtask

   task automatic test_back_to_back();
      pulse_start(8'h10, 8'h5A);
      start = 1'b1;
      for (int i = 0; i <= 182; i++) begin
         if (i > 0) @(negedge clk);
         n_checks++;
         if ({cs_n, rd_n, wr_n, ad_n, ad_oe, busy, fin_rd} !== exp_vec(i % 61, 20, 10, 20, 10)) begin
            n_fail++;
            $display("FAIL b2b_pins: cyc %0d got %b required %b", i,
                     {cs_n, rd_n, wr_n, ad_n, ad_oe, busy, fin_rd}, exp_vec(i % 61, 20, 10, 20, 10));
         end
         if (i == 60 || i == 121) sb.push_back(8'h5A);
         if (i == 182) start = 1'b0;
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_end: busy %b outstanding %0d required 0 / 0", busy, sb.size());
      end
   endtask

   task automatic test_reset_mid_read();
      pulse_start(8'h23, 8'h81);
      for (int i = 1; i <= 34; i++) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({cs_n, rd_n, wr_n, ad_n, ad_oe, busy, fin_rd} !== 7'b1111000 || dato !== 8'h00 ||
          ad_out !== 8'h00) begin
         n_fail++;
         $display("FAIL midreset_async: pins %b dato %h ad_out %h required 1111000 / 00 / 00",
                  {cs_n, rd_n, wr_n, ad_n, ad_oe, busy, fin_rd}, dato, ad_out);
      end
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || dato !== 8'h00) begin
         n_fail++;
         $display("FAIL midreset_idle: busy %b dato %h required 0 / 00", busy, dato);
      end
      pulse_start(8'h3C, 8'hC3);
      for (int i = 0; i <= 61; i++) begin
         if (i > 0) @(negedge clk);
         n_checks++;
         if ({cs_n, rd_n, wr_n, ad_n, ad_oe, busy, fin_rd} !== exp_vec(i, 20, 10, 20, 10)) begin
            n_fail++;
            $display("FAIL midreset_restart: cyc %0d got %b required %b", i,
                     {cs_n, rd_n, wr_n, ad_n, ad_oe, busy, fin_rd}, exp_vec(i, 20, 10, 20, 10));
         end
      end
   endtask

   task automatic test_min_timing();
      addr1 = 8'h7E; bus_val1 = 8'hE7; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int i = 0; i <= 6; i++) begin
         if (i > 0) @(negedge clk);
         n_checks++;
         if ({cs_n1, rd_n1, wr_n1, ad_n1, ad_oe1, busy1, fin_rd1} !== exp_vec(i, 1, 1, 1, 1)) begin
            n_fail++;
            $display("FAIL min_pins: cyc %0d got %b required %b", i,
                     {cs_n1, rd_n1, wr_n1, ad_n1, ad_oe1, busy1, fin_rd1}, exp_vec(i, 1, 1, 1, 1));
         end
         if (i == 0) begin
            n_checks++;
            if (ad_out1 !== 8'h7E) begin
               n_fail++;
               $display("FAIL min_ad_out: got %h required 7e", ad_out1);
            end
         end
         if (i == 4) begin
            n_checks++;
            if (dato1 !== 8'hE7) begin
               n_fail++;
               $display("FAIL min_dato: got %h required e7", dato1);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_read();
      test_min_timing();
      repeat (2) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d reads outstanding, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
